// File: rtl/sar_seq_pkg.sv
// Shared definitions for the SAR ADC conversion sequencer.
//   seq_state_e  : sequencer FSM states
//   SAR_W        : SAR core result width
//   ACC_W        : oversampling accumulator width (8 conversions of 8 bits)
//   RECOVER_CYC  : cycles adc_rst is held after a conversion timeout
//   next_set_ch(): round-robin search for the next enabled channel
package sar_seq_pkg;

    localparam int unsigned SAR_W       = 8;
    localparam int unsigned ACC_W       = 11;
    localparam int unsigned RECOVER_CYC = 2;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StStart,
        StConvert,
        StAccum,
        StEmit,
        StRecover,
        StWaitTick
    } seq_state_e;

    // First set bit of mask at or after start, wrapping at n_ch. Returns start if mask is empty.
    // The descending offset loop lets the smallest offset win.
    function automatic logic [2:0] next_set_ch(input logic [7:0] mask, input logic [2:0] start,
                                               input int n_ch);
        logic [2:0] ch;
        int         idx;
        ch = start;
        for (int off = 7; off >= 0; off--) begin
            idx = (int'(start) + off) % n_ch;
            if (off < n_ch && mask[idx[2:0]]) begin
                ch = idx[2:0];
            end
        end
        return ch;
    endfunction

endpackage

// File: rtl/sar_tick_gen.sv
// Sample-period tick generator.
//   clk, rst   : clock, synchronous active-high reset
//   i_enable   : run; counter is held at 0 while low
//   i_period   : tick every i_period+1 clocks
//   o_tick     : one-cycle pulse in the cycle the counter wraps
module sar_tick_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_period,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_wrap;

    // >= rather than == so a period lowered mid-count still wraps promptly
    assign w_wrap = (r_cnt >= i_period);
    assign o_tick = i_enable && w_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_enable || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sar_conv_sequencer.sv
// Sequencer for the 8-bit SAR ADC core: periodic trigger, round-robin channel scan, settle delay,
// cnvst pulse, eoc capture, 2^k oversampling average, timeout recovery, valid/ready result port.
//   clk, rst          : clock, synchronous active-high reset
//   i_enable          : run scan (low: finish current conversion, then idle)
//   i_period          : sample tick every i_period+1 clocks
//   i_ch_mask         : enabled channels
//   i_osr_log2        : conversions per result = 2^i_osr_log2
//   i_clear_err       : clear sticky error flags
//   o_mux_sel         : analog mux select
//   o_cnvst           : one-cycle conversion start to SAR core
//   o_adc_rst         : SAR core reset during timeout recovery
//   i_eoc, i_sar      : end of conversion and result from SAR core
//   o_res_valid/i_res_ready/o_res_data/o_res_ch : result port
//   o_err_timeout/o_err_overrun/o_err_late      : sticky error flags
module sar_conv_sequencer
    import sar_seq_pkg::*;
#(
    parameter  int unsigned N_CH    = 4,
    parameter  int unsigned DIV_W   = 16,
    parameter  int unsigned SETTLE  = 2,
    parameter  int unsigned TIMEOUT = 64,
    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_period,
    input  logic [N_CH-1:0]  i_ch_mask,
    input  logic [1:0]       i_osr_log2,
    input  logic             i_clear_err,
    output logic [CH_W-1:0]  o_mux_sel,
    output logic             o_cnvst,
    output logic             o_adc_rst,
    input  logic             i_eoc,
    input  logic [SAR_W-1:0] i_sar,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [SAR_W-1:0] o_res_data,
    output logic [CH_W-1:0]  o_res_ch,
    output logic             o_err_timeout,
    output logic             o_err_overrun,
    output logic             o_err_late
);

    localparam int unsigned       TMR_W       = 16;
    localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] RECOVER_LAST = TMR_W'(RECOVER_CYC - 1);

    seq_state_e       r_state, w_state_nxt;
    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
    logic [CH_W-1:0]  r_ptr, w_ptr_nxt;
    logic [CH_W-1:0]  r_mux_sel, w_mux_sel_nxt;
    logic [1:0]       r_osr, w_osr_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [3:0]       r_ns, w_ns_nxt;
    logic             r_abort, w_abort_nxt;
    logic             r_res_valid, w_res_valid_nxt;
    logic [SAR_W-1:0] r_res_data, w_res_data_nxt;
    logic [CH_W-1:0]  r_res_ch, w_res_ch_nxt;
    logic             r_err_timeout, w_err_timeout_nxt;
    logic             r_err_overrun, w_err_overrun_nxt;
    logic             r_err_late, w_err_late_nxt;

    logic             w_tick;
    logic             w_mask_nz;
    logic [7:0]       w_mask_ext;
    logic [CH_W-1:0]  w_next_ch;
    logic [CH_W-1:0]  w_ptr_after;
    logic             w_enter_settle;
    logic             w_emit;
    logic             w_set_timeout;
    logic             w_set_overrun;
    logic             w_set_late;

    sar_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .i_enable (i_enable),
        .i_period (i_period),
        .o_tick   (w_tick)
    );

    // r_ptr is the first candidate for the next group; the chosen channel is the first enabled
    // one at or after it, so the scan starts at channel 0 after reset.
    always_comb begin
        w_mask_ext             = '0;
        w_mask_ext[N_CH-1:0]   = i_ch_mask;
        w_mask_nz              = |i_ch_mask;
        w_next_ch              = CH_W'(next_set_ch(w_mask_ext, 3'(r_ptr), int'(N_CH)));
        w_ptr_after            = (int'(w_next_ch) == int'(N_CH) - 1) ? '0 : w_next_ch + 1'b1;
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nxt    = r_state;
        w_tmr_nxt      = r_tmr;
        w_ptr_nxt      = r_ptr;
        w_mux_sel_nxt  = r_mux_sel;
        w_osr_nxt      = r_osr;
        w_acc_nxt      = r_acc;
        w_ns_nxt       = r_ns;
        w_abort_nxt    = r_abort;
        w_enter_settle = 1'b0;
        w_emit         = 1'b0;
        w_set_timeout  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_enable && w_mask_nz && w_tick) begin
                    w_enter_settle = 1'b1;
                end
            end
            StSettle: begin
                if (!i_enable) begin
                    w_state_nxt = StIdle;
                end else if (r_tmr == SETTLE_LAST) begin
                    w_state_nxt = StStart;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            StStart: begin
                // Timer counts cycles since cnvst
                w_state_nxt = StConvert;
                w_tmr_nxt   = TMR_W'(1);
                if (!i_enable) begin
                    w_abort_nxt = 1'b1;
                end
            end
            StConvert: begin
                // Once cnvst is out the core is never aborted; a disable only discards the group
                if (!i_enable) begin
                    w_abort_nxt = 1'b1;
                end
                if (i_eoc) begin
                    w_acc_nxt   = r_acc + ACC_W'(i_sar);
                    w_ns_nxt    = r_ns + 1'b1;
                    w_state_nxt = StAccum;
                end else if (r_tmr == TIMEOUT_LAST) begin
                    w_state_nxt   = StRecover;
                    w_tmr_nxt     = '0;
                    w_set_timeout = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            StAccum: begin
                if (r_abort || !i_enable) begin
                    w_state_nxt = StIdle;
                end else if (r_ns == (4'd1 << r_osr)) begin
                    // Result register loads here so res_valid is up during EMIT
                    w_emit      = 1'b1;
                    w_state_nxt = StEmit;
                end else begin
                    w_state_nxt = StStart;
                end
            end
            StEmit: begin
                w_state_nxt = i_enable ? StWaitTick : StIdle;
            end
            StRecover: begin
                if (r_tmr == RECOVER_LAST) begin
                    w_state_nxt = i_enable ? StWaitTick : StIdle;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            StWaitTick: begin
                if (!i_enable) begin
                    w_state_nxt = StIdle;
                end else if (w_tick) begin
                    if (w_mask_nz) begin
                        w_enter_settle = 1'b1;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Entry into SETTLE samples channel, mask and osr and starts a fresh group
        if (w_enter_settle) begin
            w_state_nxt   = StSettle;
            w_tmr_nxt     = '0;
            w_mux_sel_nxt = w_next_ch;
            w_ptr_nxt     = w_ptr_after;
            w_osr_nxt     = i_osr_log2;
            w_acc_nxt     = '0;
            w_ns_nxt      = '0;
            w_abort_nxt   = 1'b0;
        end
    end

    // Result holding register and sticky errors
    always_comb begin
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        w_res_ch_nxt    = r_res_ch;
        w_set_overrun   = 1'b0;
        w_set_late      = w_tick && (r_state != StIdle) && (r_state != StWaitTick);

        if (r_res_valid && i_res_ready) begin
            w_res_valid_nxt = 1'b0;
        end
        if (w_emit) begin
            // A result accepted this very cycle frees the register for the new one
            if (r_res_valid && !i_res_ready) begin
                w_set_overrun = 1'b1;
            end else begin
                w_res_valid_nxt = 1'b1;
                w_res_data_nxt  = SAR_W'(r_acc >> r_osr);
                w_res_ch_nxt    = r_mux_sel;
            end
        end

        // Set wins over clear
        w_err_timeout_nxt = w_set_timeout ? 1'b1 : (i_clear_err ? 1'b0 : r_err_timeout);
        w_err_overrun_nxt = w_set_overrun ? 1'b1 : (i_clear_err ? 1'b0 : r_err_overrun);
        w_err_late_nxt    = w_set_late    ? 1'b1 : (i_clear_err ? 1'b0 : r_err_late);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_tmr         <= '0;
            r_ptr         <= '0;
            r_mux_sel     <= '0;
            r_osr         <= '0;
            r_acc         <= '0;
            r_ns          <= '0;
            r_abort       <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_ch      <= '0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_late    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tmr         <= w_tmr_nxt;
            r_ptr         <= w_ptr_nxt;
            r_mux_sel     <= w_mux_sel_nxt;
            r_osr         <= w_osr_nxt;
            r_acc         <= w_acc_nxt;
            r_ns          <= w_ns_nxt;
            r_abort       <= w_abort_nxt;
            r_res_valid   <= w_res_valid_nxt;
            r_res_data    <= w_res_data_nxt;
            r_res_ch      <= w_res_ch_nxt;
            r_err_timeout <= w_err_timeout_nxt;
            r_err_overrun <= w_err_overrun_nxt;
            r_err_late    <= w_err_late_nxt;
        end
    end

    assign o_mux_sel     = r_mux_sel;
    assign o_cnvst       = (r_state == StStart);
    assign o_adc_rst     = (r_state == StRecover);
    assign o_res_valid   = r_res_valid;
    assign o_res_data    = r_res_data;
    assign o_res_ch      = r_res_ch;
    assign o_err_timeout = r_err_timeout;
    assign o_err_overrun = r_err_overrun;
    assign o_err_late    = r_err_late;

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Directed bench for sar_conv_sequencer with a behavioural SAR core (eoc 20 cycles after cnvst).
module tb_sar_conv_sequencer;

    localparam int EOC_DLY = 20;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] period;
    logic [3:0]  ch_mask;
    logic [1:0]  osr_log2;
    logic        clear_err;
    logic [1:0]  mux_sel;
    logic        cnvst;
    logic        adc_rst;
    logic        eoc;
    logic [7:0]  sar;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [1:0]  res_ch;
    logic        err_timeout;
    logic        err_overrun;
    logic        err_late;

    sar_conv_sequencer #(
        .N_CH    (4),
        .DIV_W   (16),
        .SETTLE  (2),
        .TIMEOUT (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (enable),
        .i_period      (period),
        .i_ch_mask     (ch_mask),
        .i_osr_log2    (osr_log2),
        .i_clear_err   (clear_err),
        .o_mux_sel     (mux_sel),
        .o_cnvst       (cnvst),
        .o_adc_rst     (adc_rst),
        .i_eoc         (eoc),
        .i_sar         (sar),
        .o_res_valid   (res_valid),
        .i_res_ready   (res_ready),
        .o_res_data    (res_data),
        .o_res_ch      (res_ch),
        .o_err_timeout (err_timeout),
        .o_err_overrun (err_overrun),
        .o_err_late    (err_late)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // SAR model / monitor state
    logic [7:0] sar_tab [4];
    int         sar_idx    = 0;
    int         suppress_n = 0;
    int         cd         = 0;
    bit         pending    = 0;
    int         viol       = 0;
    bit         prev_valid = 0;
    int         cnvst_q [$];
    int         eoc_q [$];
    int         rise_q [$];
    int         adcrst_q [$];
    int         rdata_q [$];
    int         rch_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Behavioural SAR core plus output monitor, all at the falling edge
    initial begin
        eoc = 1'b0;
        sar = 8'd0;
        forever begin
            @(negedge clk);
            eoc = 1'b0;
            if (res_valid && res_ready) begin
                rdata_q.push_back(int'(res_data));
                rch_q.push_back(int'(res_ch));
            end
            if (res_valid && !prev_valid) rise_q.push_back(cyc);
            prev_valid = res_valid;
            if (adc_rst) begin
                adcrst_q.push_back(cyc);
                pending = 0;
            end
            if (rst) begin
                cd      = 0;
                pending = 0;
            end else if (cnvst) begin
                cnvst_q.push_back(cyc);
                if (pending) viol++;
                pending = 1;
                if (suppress_n > 0) suppress_n--;
                else cd = EOC_DLY;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    eoc = 1'b1;
                    sar = sar_tab[sar_idx % 4];
                    sar_idx++;
                    eoc_q.push_back(cyc);
                    pending = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int qsize(input int which);
        case (which)
            0:       return cnvst_q.size();
            1:       return rdata_q.size();
            default: return eoc_q.size();
        endcase
    endfunction

    // which: 0 = cnvst pulses, 1 = accepted results, 2 = eoc pulses
    task automatic wait_q(input string tag, input int which, input int n, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (qsize(which) >= n) done = 1;
        end
        if (!done) chk({tag, "_wait"}, qsize(which), n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        enable    = 1'b0;
        clear_err = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        suppress_n = 0;
        sar_idx    = 0;
        cnvst_q.delete();
        eoc_q.delete();
        rise_q.delete();
        adcrst_q.delete();
        rdata_q.delete();
        rch_q.delete();
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_cnvst"}, cnvst, 0);
        chk({pfx, "_adc_rst"}, adc_rst, 0);
        chk({pfx, "_res_valid"}, res_valid, 0);
        chk({pfx, "_mux_sel"}, mux_sel, 0);
        chk({pfx, "_res_data"}, res_data, 0);
        chk({pfx, "_res_ch"}, res_ch, 0);
        chk({pfx, "_err_timeout"}, err_timeout, 0);
        chk({pfx, "_err_overrun"}, err_overrun, 0);
        chk({pfx, "_err_late"}, err_late, 0);
    endtask

    initial begin
        int e;
        int exp_ch [4];
        logic [7:0] exp_d [4];
        rst       = 1'b1;
        enable    = 1'b0;
        period    = 16'd0;
        ch_mask   = 4'd0;
        osr_log2  = 2'd0;
        clear_err = 1'b0;
        res_ready = 1'b1;
        sar_tab   = '{8'd0, 8'd0, 8'd0, 8'd0};

        // Reset state
        do_reset();
        check_zero("reset");

        // Round-robin scan of channels 0 and 2, no oversampling
        sar_tab  = '{8'd11, 8'd22, 8'd33, 8'd44};
        ch_mask  = 4'b0101;
        osr_log2 = 2'd0;
        period   = 16'd99;
        @(negedge clk);
        enable = 1'b1;
        e      = cyc;
        wait_q("scan_res", 1, 4, 600);
        exp_ch = '{0, 2, 0, 2};
        exp_d  = '{8'd11, 8'd22, 8'd33, 8'd44};
        if (rdata_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("scan_ch%0d", i), rch_q[i], exp_ch[i]);
                chk($sformatf("scan_data%0d", i), rdata_q[i], exp_d[i]);
            end
        end
        chk("scan_first_cnvst", cnvst_q[0] - e, 102);
        chk("scan_cnvst_gap1", cnvst_q[1] - cnvst_q[0], 100);
        chk("scan_cnvst_gap2", cnvst_q[2] - cnvst_q[1], 100);
        chk("scan_eoc_to_valid", rise_q[0] - eoc_q[0], 2);
        chk("scan_err_late", err_late, 0);
        enable = 1'b0;

        // 4x oversampling: 10+11+12+13 = 46, >>2 = 11; osr change mid-group ignored
        do_reset();
        sar_tab  = '{8'd10, 8'd11, 8'd12, 8'd13};
        ch_mask  = 4'b0001;
        osr_log2 = 2'd2;
        period   = 16'd199;
        @(negedge clk);
        enable = 1'b1;
        wait_q("osr_first_cnvst", 0, 1, 300);
        osr_log2 = 2'd0;
        wait_q("osr_res", 1, 1, 300);
        chk("osr_n_res", rdata_q.size(), 1);
        if (rdata_q.size() >= 1) begin
            chk("osr_data", rdata_q[0], 11);
            chk("osr_ch", rch_q[0], 0);
        end
        chk("osr_n_cnvst", cnvst_q.size(), 4);
        enable = 1'b0;

        // Timeout on channel 0, recovery, then channel 1 converts
        do_reset();
        sar_tab    = '{8'd77, 8'd78, 8'd79, 8'd80};
        ch_mask    = 4'b0011;
        osr_log2   = 2'd0;
        period     = 16'd199;
        suppress_n = 1;
        @(negedge clk);
        enable = 1'b1;
        wait_q("tmo_res", 1, 1, 700);
        chk("tmo_adc_rst_at", adcrst_q[0] - cnvst_q[0], 64);
        chk("tmo_adc_rst_len", adcrst_q.size(), 2);
        chk("tmo_err_timeout", err_timeout, 1);
        chk("tmo_n_cnvst", cnvst_q.size(), 2);
        if (rdata_q.size() >= 1) begin
            chk("tmo_res_ch", rch_q[0], 1);
            chk("tmo_res_data", rdata_q[0], 77);
        end
        chk("tmo_err_late", err_late, 0);
        enable = 1'b0;

        // Overrun: consumer stalls across two results
        do_reset();
        sar_tab   = '{8'd31, 8'd32, 8'd33, 8'd34};
        ch_mask   = 4'b0101;
        period    = 16'd99;
        res_ready = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_q("ovr_eoc", 2, 2, 400);
        repeat (5) @(negedge clk);
        chk("ovr_valid", res_valid, 1);
        chk("ovr_data_kept", res_data, 31);
        chk("ovr_ch_kept", res_ch, 0);
        chk("ovr_err", err_overrun, 1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("ovr_cleared", err_overrun, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("ovr_valid_drop", res_valid, 0);
        enable = 1'b0;

        // Ticks faster than a conversion
        do_reset();
        sar_tab = '{8'd1, 8'd2, 8'd3, 8'd4};
        ch_mask = 4'b0001;
        period  = 16'd5;
        @(negedge clk);
        enable = 1'b1;
        wait_q("late_res", 1, 3, 300);
        chk("late_err", err_late, 1);
        chk("late_err_timeout", err_timeout, 0);
        if (rdata_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("late_data%0d", i), rdata_q[i], i + 1);
            end
        end
        enable = 1'b0;

        // Disable mid-conversion: eoc consumed, result discarded, back to idle
        do_reset();
        sar_tab = '{8'd90, 8'd91, 8'd92, 8'd93};
        ch_mask = 4'b0001;
        period  = 16'd99;
        @(negedge clk);
        enable = 1'b1;
        wait_q("abort_cnvst", 0, 1, 200);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_eoc_seen", eoc_q.size(), 1);
        chk("abort_no_result", rise_q.size(), 0);
        chk("abort_n_cnvst", cnvst_q.size(), 1);
        chk("abort_no_adc_rst", adcrst_q.size(), 0);
        // Empty mask while enabled: no conversions
        ch_mask = 4'b0000;
        enable  = 1'b1;
        repeat (250) @(negedge clk);
        chk("mask0_n_cnvst", cnvst_q.size(), 1);
        // Sequencer is idle and restarts once a channel is enabled
        ch_mask = 4'b0001;
        wait_q("restart_cnvst", 0, 2, 200);
        chk("restart_n_cnvst", cnvst_q.size(), 2);
        enable = 1'b0;

        // Reset in the middle of a conversion
        do_reset();
        ch_mask = 4'b0100;
        period  = 16'd99;
        @(negedge clk);
        enable = 1'b1;
        wait_q("rstmid_cnvst", 0, 1, 200);
        repeat (5) @(negedge clk);
        chk("rstmid_mux_sel", mux_sel, 2);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check_zero("rstmid");
        do_reset();

        chk("cnvst_exclusive", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
